// File: rtl/fabric_cfg_loader_if.sv
// Configuration frame stream between the bitstream source and fabric_cfg_loader.
// Plain valid/ready handshake. s_last marks the final frame word.
interface fabric_cfg_loader_if #(
  parameter int CFG_W = 224
);
  logic             s_valid;
  logic [CFG_W-1:0] s_data;
  logic             s_last;
  logic             s_ready;

  // Source side (host / bitstream reader)
  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  // Sink side (loader)
  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/fabric_cfg_loader.sv
// fabric_cfg_loader: synthesizable configuration sequencer for the fpga fabric.
// It accepts frames over a valid/ready stream and writes each one to the fabric
// via configs_in and the one-hot configs_en. It then arms ff_en and raises rdy.
// Optional build macro: CFG_CHECKSUM_EN adds a trailing XOR checksum word
// that is checked in a CHK state before the fabric is armed.
module fabric_cfg_loader #(
  parameter int CFG_W      = 224,
  parameter int NUM_FRAMES = 245,
  parameter int PRE_WAIT   = 10,
  parameter int POST_WAIT  = 10,
  parameter int RDY_DELAY  = 10
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  fabric_cfg_loader_if.slave    stream,
  output logic [CFG_W-1:0]      configs_in,
  output logic [NUM_FRAMES-1:0] configs_en,
  output logic                  ff_en,
  output logic                  rdy,
  output logic                  busy,
  output logic                  err
);

  localparam int MAXW_A = (PRE_WAIT > POST_WAIT) ? PRE_WAIT : POST_WAIT;
  localparam int MAXW   = (MAXW_A > RDY_DELAY) ? MAXW_A : RDY_DELAY;
  localparam int WW     = (MAXW < 1) ? 1 : $clog2(MAXW + 1);
  localparam int FW     = $clog2(NUM_FRAMES + 1);

  localparam logic [WW-1:0] PRE_END  = WW'(PRE_WAIT);
  localparam logic [WW-1:0] POST_END = WW'(POST_WAIT);
  localparam logic [WW-1:0] RDY_END  = WW'(RDY_DELAY);
  localparam logic [FW-1:0] LAST_IDX = FW'(NUM_FRAMES - 1);

`ifdef CFG_CHECKSUM_EN
  typedef enum logic [3:0] {
    IDLE, PRE, LOAD, COMMIT, POST, ARM, DONE, ERR, CHK
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, PRE, LOAD, COMMIT, POST, ARM, DONE, ERR
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [FW-1:0]         frame_q, frame_d;
  logic [CFG_W-1:0]      cfg_in_q, cfg_in_d;
  logic [NUM_FRAMES-1:0] cfg_en_q, cfg_en_d;
  logic                  ff_en_q, ff_en_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  ready_q, ready_d;
`ifdef CFG_CHECKSUM_EN
  logic [CFG_W-1:0]      acc_q, acc_d;
`endif

  logic accept;
  logic frame_is_last;

  assign accept        = ready_q & stream.s_valid;
  assign frame_is_last = (frame_q == LAST_IDX);

  // Next-state and next-output decode for the load sequencer
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    frame_d  = frame_q;
    cfg_in_d = cfg_in_q;
    cfg_en_d = cfg_en_q;
    ff_en_d  = ff_en_q;
    rdy_d    = rdy_q;
    busy_d   = busy_q;
    err_d    = err_q;
    ready_d  = ready_q;
`ifdef CFG_CHECKSUM_EN
    acc_d    = acc_q;
`endif

    unique case (state_q)
      IDLE, DONE, ERR: begin
        // busy is low in all three, so a start pulse is honoured here only
        if (start) begin
          state_d  = PRE;
          busy_d   = 1'b1;
          ff_en_d  = 1'b0;
          rdy_d    = 1'b0;
          err_d    = 1'b0;
          wait_d   = '0;
          frame_d  = '0;
          cfg_en_d = '0;
          ready_d  = 1'b0;
`ifdef CFG_CHECKSUM_EN
          acc_d    = '0;
`endif
        end
      end

      PRE: begin
        if (wait_q == PRE_END) begin
          state_d  = LOAD;
          cfg_en_d = NUM_FRAMES'(1);
          ready_d  = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      LOAD: begin
        if (accept) begin
          cfg_in_d = stream.s_data;
          ready_d  = 1'b0;
          // s_last must appear exactly on the final frame index
          if (stream.s_last != frame_is_last) begin
            state_d  = ERR;
            err_d    = 1'b1;
            busy_d   = 1'b0;
            cfg_en_d = '0;
            ff_en_d  = 1'b0;
            rdy_d    = 1'b0;
          end else begin
            state_d = COMMIT;
          end
        end
      end

      COMMIT: begin
        // The fabric captures configs_in under the current one-hot bit this cycle
        cfg_en_d = cfg_en_q << 1;
        frame_d  = frame_q + FW'(1);
`ifdef CFG_CHECKSUM_EN
        acc_d    = acc_q ^ cfg_in_q;
`endif
        if (frame_is_last) begin
          wait_d = '0;
`ifdef CFG_CHECKSUM_EN
          state_d = CHK;
          ready_d = 1'b1;
`else
          state_d = POST;
`endif
        end else begin
          state_d = LOAD;
          ready_d = 1'b1;
        end
      end

`ifdef CFG_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          ready_d = 1'b0;
          if (stream.s_data == acc_q) begin
            state_d = POST;
            wait_d  = '0;
          end else begin
            state_d  = ERR;
            err_d    = 1'b1;
            busy_d   = 1'b0;
            cfg_en_d = '0;
            ff_en_d  = 1'b0;
            rdy_d    = 1'b0;
          end
        end
      end
`endif

      POST: begin
        if (wait_q == POST_END) begin
          state_d = ARM;
          ff_en_d = 1'b1;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      ARM: begin
        if (wait_q == RDY_END) begin
          state_d = DONE;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        cfg_en_d = '0;
        ready_d  = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      frame_q  <= '0;
      cfg_in_q <= '0;
      cfg_en_q <= '0;
      ff_en_q  <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      frame_q  <= frame_d;
      cfg_in_q <= cfg_in_d;
      cfg_en_q <= cfg_en_d;
      ff_en_q  <= ff_en_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
`ifdef CFG_CHECKSUM_EN
      acc_q    <= acc_d;
`endif
    end
  end

  assign stream.s_ready = ready_q;
  assign configs_in     = cfg_in_q;
  assign configs_en     = cfg_en_q;
  assign ff_en          = ff_en_q;
  assign rdy            = rdy_q;
  assign busy           = busy_q;
  assign err            = err_q;

endmodule

// File: tb/tb_fabric_cfg_loader.sv
// Self-checking bench for fabric_cfg_loader (CFG_W=8, NUM_FRAMES=4, waits=2).
// Expected values come from a transaction-level model: the frame index of
// each word, the s_last framing rule, the XOR checksum and the wait lengths.
module tb_fabric_cfg_loader;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int PW = 2;
  localparam int QW = 2;
  localparam int RD = 2;

  logic         clock = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] configs_in;
  logic [N-1:0] configs_en;
  logic         ff_en, rdy, busy, err;

  fabric_cfg_loader_if #(.CFG_W(W)) sif ();

  fabric_cfg_loader #(
    .CFG_W(W), .NUM_FRAMES(N), .PRE_WAIT(PW), .POST_WAIT(QW), .RDY_DELAY(RD)
  ) dut (
    .clock(clock), .rst(rst), .start(start), .stream(sif.slave),
    .configs_in(configs_in), .configs_en(configs_en),
    .ff_en(ff_en), .rdy(rdy), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Per-load stimulus description
  logic [W-1:0] frm [N];
  bit           lst [N];
  int unsigned  gap [N];
  logic [W-1:0] chk_word;
  bit           poke_start;
  int           abort_at;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_cfg_en"}, 64'(configs_en), 64'd0);
    check({tag, "_cfg_in"}, 64'(configs_in), 64'd0);
    check({tag, "_ff_en"},  64'(ff_en), 64'd0);
    check({tag, "_rdy"},    64'(rdy), 64'd0);
    check({tag, "_busy"},   64'(busy), 64'd0);
    check({tag, "_err"},    64'(err), 64'd0);
    check({tag, "_sready"}, 64'(sif.s_ready), 64'd0);
  endtask

  task automatic check_err_state(input string tag);
    check({tag, "_err"},    64'(err), 64'd1);
    check({tag, "_busy"},   64'(busy), 64'd0);
    check({tag, "_cfg_en"}, 64'(configs_en), 64'd0);
    check({tag, "_ff_en"},  64'(ff_en), 64'd0);
    check({tag, "_rdy"},    64'(rdy), 64'd0);
    // Junk traffic while in error must not be taken
    sif.s_valid = 1'b1; sif.s_data = W'($urandom);
    for (int k = 0; k < 3; k++) begin
      tick();
      check({tag, "_hold_sready"}, 64'(sif.s_ready), 64'd0);
      check({tag, "_hold_err"},    64'(err), 64'd1);
      check({tag, "_hold_ff_en"},  64'(ff_en), 64'd0);
    end
    sif.s_valid = 1'b0;
  endtask

  // start pulse, then PRE lasts PW+1 cycles before the stream opens
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("pre_busy",   64'(busy), 64'd1);
    check("pre_ff_en",  64'(ff_en), 64'd0);
    check("pre_rdy",    64'(rdy), 64'd0);
    check("pre_err",    64'(err), 64'd0);
    check("pre_cfg_en", 64'(configs_en), 64'd0);
    sif.s_valid = 1'b1; sif.s_data = W'($urandom); sif.s_last = 1'b1;
    for (int k = 0; k < PW; k++) begin
      tick();
      check("pre_sready", 64'(sif.s_ready), 64'd0);
    end
    tick();
    sif.s_valid = 1'b0; sif.s_last = 1'b0;
    check("load_sready", 64'(sif.s_ready), 64'd1);
    check("load_cfg_en0", 64'(configs_en), 64'd1);
  endtask

  // Runs one full load from start; returns 1 if the model expects success
  task automatic run_load(output bit ok);
    bit           failed;
    logic [W-1:0] acc;
    failed = 1'b0;
    acc    = '0;
    ok     = 1'b0;
    do_start();
    for (int i = 0; i < N && !failed; i++) begin
      if (i == abort_at) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_idle_zero("rst_mid");
        for (int k = 0; k < PW + 3; k++) begin
          tick();
          check("rst_idle_sready", 64'(sif.s_ready), 64'd0);
          check("rst_idle_busy",   64'(busy), 64'd0);
        end
        return;
      end
      for (int unsigned g = 0; g < gap[i]; g++) begin
        if (poke_start && g == 0) start = 1'b1;
        tick();
        start = 1'b0;
        check("stall_cfg_en", 64'(configs_en), 64'd1 << i);
        check("stall_sready", 64'(sif.s_ready), 64'd1);
        check("stall_busy",   64'(busy), 64'd1);
      end
      sif.s_valid = 1'b1; sif.s_data = frm[i]; sif.s_last = lst[i];
      tick();
      // Keep junk valid during COMMIT: it must be ignored
      sif.s_data = W'($urandom); sif.s_last = 1'b1;
      if (lst[i] != (i == N - 1)) begin
        failed = 1'b1;
        check_err_state("frame_err");
      end else begin
        check("commit_cfg_en", 64'(configs_en), 64'd1 << i);
        check("commit_cfg_in", 64'(configs_in), 64'(frm[i]));
        check("commit_sready", 64'(sif.s_ready), 64'd0);
        acc ^= frm[i];
        tick();
        sif.s_valid = 1'b0; sif.s_last = 1'b0;
        if (i < N - 1) begin
          check("next_cfg_en", 64'(configs_en), 64'd1 << (i + 1));
          check("next_sready", 64'(sif.s_ready), 64'd1);
        end else begin
          check("after_cfg_en", 64'(configs_en), 64'd0);
          check("after_cfg_in", 64'(configs_in), 64'(frm[i]));
        end
      end
    end
    if (failed) return;
`ifdef CFG_CHECKSUM_EN
    check("chk_sready", 64'(sif.s_ready), 64'd1);
    check("chk_cfg_en", 64'(configs_en), 64'd0);
    sif.s_valid = 1'b1; sif.s_data = chk_word; sif.s_last = 1'b0;
    tick();
    sif.s_valid = 1'b0;
    if (chk_word !== acc) begin
      check_err_state("chk_err");
      return;
    end
`endif
    // POST: ff_en rises QW+1 cycles after entry; rdy RD+1 cycles after that
    sif.s_valid = 1'b1; sif.s_data = W'($urandom);
    for (int k = 0; k < QW; k++) begin
      check("post_ff_en", 64'(ff_en), 64'd0);
      check("post_sready", 64'(sif.s_ready), 64'd0);
      tick();
    end
    check("post_ff_en_last", 64'(ff_en), 64'd0);
    tick();
    check("arm_ff_en", 64'(ff_en), 64'd1);
    check("arm_busy",  64'(busy), 64'd1);
    for (int k = 0; k < RD; k++) begin
      check("arm_rdy", 64'(rdy), 64'd0);
      tick();
    end
    check("arm_rdy_last", 64'(rdy), 64'd0);
    tick();
    sif.s_valid = 1'b0;
    check("done_rdy",    64'(rdy), 64'd1);
    check("done_busy",   64'(busy), 64'd0);
    check("done_ff_en",  64'(ff_en), 64'd1);
    check("done_err",    64'(err), 64'd0);
    check("done_cfg_en", 64'(configs_en), 64'd0);
    tick();
    check("done_hold_rdy", 64'(rdy), 64'd1);
    ok = 1'b1;
  endtask

  task automatic set_frames(input logic [W-1:0] a, b, c, d);
    frm[0] = a; frm[1] = b; frm[2] = c; frm[3] = d;
    for (int i = 0; i < N; i++) begin
      lst[i] = (i == N - 1);
      gap[i] = 0;
    end
    chk_word   = a ^ b ^ c ^ d;
    poke_start = 1'b0;
    abort_at   = -1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit ok;
    sif.s_valid = 1'b0; sif.s_data = '0; sif.s_last = 1'b0;
    rst = 1'b0;
    tick(); tick();
    check_idle_zero("reset");
    rst = 1'b1;
    tick();
    check_idle_zero("idle");

    // Nominal load
    set_frames(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    run_load(ok);
    check("nominal_ok", 64'(ok), 64'd1);

    // Restart from DONE
    set_frames(8'h5A, 8'h3C, 8'h99, 8'h0F);
    run_load(ok);
    check("restart_ok", 64'(ok), 64'd1);

    // Early last on frame 1, then recovery
    set_frames(8'h11, 8'h22, 8'h33, 8'h44);
    lst[1] = 1'b1;
    run_load(ok);
    check("early_last_ok", 64'(ok), 64'd0);
    set_frames(8'h12, 8'h34, 8'h56, 8'h78);
    run_load(ok);
    check("recover_ok", 64'(ok), 64'd1);

    // Missing last
    set_frames(8'h01, 8'h80, 8'h7F, 8'hFE);
    lst[N-1] = 1'b0;
    run_load(ok);
    check("missing_last_ok", 64'(ok), 64'd0);

    // Stalls with a start pulse while busy
    set_frames(8'hC0, 8'hDE, 8'hBE, 8'hEF);
    for (int i = 0; i < N; i++) gap[i] = 5;
    poke_start = 1'b1;
    run_load(ok);
    check("stall_ok", 64'(ok), 64'd1);

    // Reset after frame 2 has been committed, then a fresh load
    set_frames(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    abort_at = 3;
    run_load(ok);
    check("aborted_ok", 64'(ok), 64'd0);
    set_frames(8'h10, 8'h20, 8'h30, 8'h40);
    run_load(ok);
    check("post_reset_ok", 64'(ok), 64'd1);

`ifdef CFG_CHECKSUM_EN
    set_frames(8'h01, 8'h02, 8'h04, 8'h08);
    chk_word = 8'h0F;
    run_load(ok);
    check("chk_good_ok", 64'(ok), 64'd1);
    set_frames(8'h01, 8'h02, 8'h04, 8'h08);
    chk_word = 8'h0E;
    run_load(ok);
    check("chk_bad_ok", 64'(ok), 64'd0);
`endif

    // Randomized loads: random data, gaps and occasional framing faults
    for (int r = 0; r < 12; r++) begin
      bit exp_ok;
      set_frames(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      for (int i = 0; i < N; i++) gap[i] = $urandom_range(0, 3);
      poke_start = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(0, N - 1);
        lst[k] = ~lst[k];
      end
`ifdef CFG_CHECKSUM_EN
      if ($urandom_range(0, 3) == 0) chk_word = chk_word ^ W'($urandom_range(1, 255));
`endif
      // Model: the first frame whose s_last disagrees with its index faults
      exp_ok = 1'b1;
      for (int i = 0; i < N; i++)
        if (lst[i] != (i == N - 1)) exp_ok = 1'b0;
`ifdef CFG_CHECKSUM_EN
      if (chk_word !== (frm[0] ^ frm[1] ^ frm[2] ^ frm[3])) exp_ok = 1'b0;
`endif
      run_load(ok);
      check("rand_ok", 64'(ok), 64'(exp_ok));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
